// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Bundles the fetch unit's bus signals into one interface:
//               the combinational instruction-memory port, the downstream
//               redirect request and the decode-side valid/ready output.
//               master : the fetch unit (drives imem_addr, out_*)
//               slave  : the environment (drives imem_instr, redirect_*,
//                        out_ready)
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if;
  // instruction memory
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  // redirect from branch/jump resolution
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // decode-side handshake
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Sequential instruction fetch into a small FIFO buffer.
//               The fetch PC addresses a combinational instruction memory;
//               each fetched {pc, instr} pair is pushed into a FIFO whose
//               head is presented to decode with a valid/ready handshake.
//               A redirect flushes the buffer and reloads the fetch PC.
// Ports       : clk          - clock, all state on rising edge
//               reset        - synchronous, active-high reset
//               bus (master) - imem_addr/imem_instr, redirect_valid/pc,
//                              out_valid/out_instr/out_pc/out_ready
//               perf_fetched - push counter  (FETCH_PERF_COUNTERS_EN only)
//               perf_stall   - stall counter (FETCH_PERF_COUNTERS_EN only)
// Parameters  : RESET_PC   - first fetch address after reset
//               FIFO_DEPTH - buffer depth, power of two, >= 2
// Macro       : FETCH_PERF_COUNTERS_EN - adds the two performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_stall
`endif
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]        r_fetch_pc;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic [31:0]        r_buf_pc    [FIFO_DEPTH];
  logic [31:0]        r_buf_instr [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic w_out_valid;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_stall;

  assign w_out_valid = (r_count != '0);
  assign w_full      = (r_count == c_full_cnt);
  // A pop only counts when no redirect discards it.
  assign w_pop       = w_out_valid && bus.out_ready && !bus.redirect_valid;
  // A full buffer may still accept the new word if the head leaves this cycle.
  assign w_push      = !bus.redirect_valid && (!w_full || w_pop);
  assign w_stall     = !bus.redirect_valid && w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Fetch PC and FIFO pointers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        // Natural 32-bit overflow gives the required wrap to zero.
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage needs no reset: entries are only visible when counted.
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_buf_pc[r_wr_ptr]    <= r_fetch_pc;
      r_buf_instr[r_wr_ptr] <= bus.imem_instr;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all from registers; data forced to zero while the buffer is
  // empty so reset presents clean zeros.
  // --------------------------------------------------------------------------
  assign bus.imem_addr = r_fetch_pc;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_out_valid ? r_buf_pc[r_rd_ptr]    : 32'h0;
  assign bus.out_instr = w_out_valid ? r_buf_instr[r_rd_ptr] : 32'h0;

`ifdef FETCH_PERF_COUNTERS_EN
  // --------------------------------------------------------------------------
  // Performance counters (wrap modulo 2^32)
  // --------------------------------------------------------------------------
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (w_stall) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`else
  // Stall detection only feeds the counters.
  logic w_unused;
  assign w_unused = w_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench for instruction_fetch_unit. A queue
//               model of the fetch buffer is checked against the DUT every
//               cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam int DEPTH = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  instruction_fetch_unit_if bus ();

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.master)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents
  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [29:0] idx;
    idx = a[31:2];
    case (idx)
      30'd0:   return 32'h2001000A;
      30'd1:   return 32'h20020014;
      30'd2:   return 32'h20030032;
      30'd3:   return 32'hAC010000;
      30'd4:   return 32'h8C040000;
      30'd5:   return 32'h10230002;
      30'd6:   return 32'h00000000;
      30'd7:   return 32'h08000000;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  assign bus.imem_instr = mem(bus.imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: buffer as a queue of {pc, instr}
  // --------------------------------------------------------------------------
  logic [63:0] mq[$];
  logic [31:0] mpc;
  logic [31:0] m_fetched;
  logic [31:0] m_stall;
  bit          m_live;
  bit          have_last;
  logic [31:0] last_acc;

  always @(negedge clk) begin
    bit pop;
    bit push;
    if (m_live) begin
      chk("imem_addr", {32'h0, bus.imem_addr}, {32'h0, mpc});
      chk("out_valid", {63'h0, bus.out_valid}, {63'h0, (mq.size() > 0)});
      if (mq.size() > 0) begin
        chk("head", {bus.out_pc, bus.out_instr}, mq[0]);
      end
`ifdef FETCH_PERF_COUNTERS_EN
      chk("perf_fetched", {32'h0, perf_fetched}, {32'h0, m_fetched});
      chk("perf_stall", {32'h0, perf_stall}, {32'h0, m_stall});
`endif
    end
    // Consecutive accepted transfers must be exactly 4 bytes apart.
    if (reset || bus.redirect_valid) begin
      have_last = 0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (have_last) chk("accept_step", {32'h0, bus.out_pc}, {32'h0, last_acc + 32'd4});
      have_last = 1;
      last_acc  = bus.out_pc;
    end
    // Next-state of the model from the inputs applied this cycle
    if (reset) begin
      mq.delete();
      mpc       = 32'h0;
      m_fetched = 0;
      m_stall   = 0;
      m_live    = 1;
    end else if (bus.redirect_valid) begin
      mq.delete();
      mpc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      pop  = (mq.size() > 0) && bus.out_ready;
      push = (mq.size() < DEPTH) || pop;
      if (!push) m_stall++;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({mpc, mem(mpc)});
        mpc = mpc + 32'd4;
        m_fetched++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  initial begin
    total = 0; bad = 0; m_live = 0; have_last = 0;
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b0;
    repeat (2) tick();
    chk("rst_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("rst_pc_instr", {bus.out_pc, bus.out_instr}, 64'h0);
    chk("rst_addr", {32'h0, bus.imem_addr}, 64'h0);

    // Streaming with out_ready held
    reset = 1'b0; bus.out_ready = 1'b1;
    tick(); chk("stream0", {bus.out_pc, bus.out_instr}, 64'h00000000_2001000A);
    tick(); chk("stream1", {bus.out_pc, bus.out_instr}, 64'h00000004_20020014);
    tick(); chk("stream2", {bus.out_pc, bus.out_instr}, 64'h00000008_20030032);
    tick(); chk("stream3", {bus.out_pc, bus.out_instr}, 64'h0000000C_AC010000);

    // Stall on a full buffer
    reset = 1'b1; tick();
    reset = 1'b0; bus.out_ready = 1'b0;
    repeat (10) tick();
    chk("stall_valid", {63'h0, bus.out_valid}, 64'h1);
    chk("stall_head", {bus.out_pc, bus.out_instr}, 64'h00000000_2001000A);
    chk("stall_addr", {32'h0, bus.imem_addr}, 64'h10);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("stall_count", {32'h0, perf_stall}, 64'd6);
    chk("fetch_count", {32'h0, perf_fetched}, 64'd4);
`endif

    // Redirect on a full buffer
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h14;
    tick();
    bus.redirect_valid = 1'b0;
    chk("redir_flush", {63'h0, bus.out_valid}, 64'h0);
    chk("redir_addr", {32'h0, bus.imem_addr}, 64'h14);
    tick();
    chk("redir_out", {bus.out_pc, bus.out_instr}, 64'h00000014_10230002);

    // Misaligned redirect target, then last of back-to-back wins
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000000E;
    tick();
    chk("align_addr", {32'h0, bus.imem_addr}, 64'hC);
    bus.redirect_pc = 32'hFFFFFFFC;
    tick();
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
    tick(); chk("wrap_pc0", {32'h0, bus.out_pc}, 64'hFFFFFFFC);
    tick(); chk("wrap_pc1", {32'h0, bus.out_pc}, 64'h0);

    // Reset mid-stream with 3 entries buffered
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1; bus.redirect_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    reset = 1'b0; bus.redirect_valid = 1'b0;
    chk("mid_rst_valid", {63'h0, bus.out_valid}, 64'h0);
    chk("mid_rst_addr", {32'h0, bus.imem_addr}, 64'h0);
    tick();
    chk("mid_rst_first", {bus.out_pc, bus.out_instr}, 64'h00000000_2001000A);

    // Random backpressure
    for (int i = 0; i < 200; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 4, is the fetch buffer depth in entries; it SHALL be a power of two and at least 2.
REQ-003 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, is a synchronous, active-high reset.
REQ-005 Port imem_addr, output, 32, is the byte address driven to the combinational instruction memory.
REQ-006 Port imem_instr, input, 32, is the instruction word returned by memory in the same cycle.
REQ-007 Port redirect_valid, input, 1, requests a PC change (branch/jump resolved downstream).
REQ-008 Port redirect_pc, input, 32, is the target byte address for the redirect.
REQ-009 Port out_valid, output, 1, indicates that out_instr/out_pc hold a valid buffered instruction.
REQ-010 Port out_instr, output, 32, is the instruction at the buffer head.
REQ-011 Port out_pc, output, 32, is the byte address of out_instr.
REQ-012 Port out_ready, input, 1, indicates the decode stage accepts the head entry this cycle.

Function
REQ-013 imem_addr SHALL equal the fetch PC register combinationally; the fetch PC is always word-aligned (bits [1:0]=00).
REQ-014 Push: in any cycle without redirect_valid where the buffer is not full, or is full and a pop occurs, {fetch PC, imem_instr} SHALL be written to the buffer tail and the fetch PC SHALL advance by 4.
REQ-015 Stall: when the buffer is full and no pop occurs, there SHALL be no push and the fetch PC SHALL hold.
REQ-016 Fetch PC increment SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-017 Pop: out_valid && out_ready SHALL remove the head entry at the clock edge.
REQ-018 out_valid SHALL be 1 exactly when the buffer is non-empty; out_instr/out_pc SHALL be driven from the head entry register with no combinational path from imem_instr.
REQ-019 Latency: an instruction fetched in cycle N SHALL first be visible at the outputs in cycle N+1.
REQ-020 Output stability: while out_valid=1 and out_ready=0, out_instr/out_pc SHALL hold.
REQ-021 Redirect: in a cycle with redirect_valid=1, the buffer SHALL be flushed (empty next cycle), any pop and push in that cycle SHALL be discarded, and the fetch PC SHALL load {redirect_pc[31:2],2'b00}.
REQ-022 After a redirect, the first instruction at the new PC SHALL reach the outputs two cycles after the redirect cycle (one fetch cycle plus one buffer cycle).
REQ-023 Back-to-back redirects: the last one SHALL win; each redirect flushes the buffer again.
REQ-024 Simultaneous push and pop on a full buffer SHALL keep the occupancy unchanged; simultaneous push and pop on an empty buffer is impossible (out_valid=0), so the result is a push only.
REQ-025 The buffer occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide; the read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-026 While reset=1: fetch PC SHALL be RESET_PC, the buffer SHALL be empty, out_valid SHALL be 0, out_instr and out_pc SHALL be 0, and no push SHALL occur.
REQ-027 Reset SHALL take priority over redirect_valid and out_ready; reset asserted mid-operation SHALL discard all buffered entries.
REQ-028 In the first cycle after reset deasserts, the unit SHALL fetch at RESET_PC.

Configuration
REQ-029 Macro FETCH_PERF_COUNTERS_EN: when it is defined, the unit SHALL add output perf_fetched (32 bits), which counts pushes, and output perf_stall (32 bits), which counts REQ-015 stall cycles; both SHALL be cleared by reset and SHALL wrap modulo 2^32.
REQ-030 When FETCH_PERF_COUNTERS_EN is undefined, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then out_ready=1 held, with memory words 0..3 = 2001000A, 20020014, 20030032, AC010000 -> out (pc, instr) = (0,2001000A), (4,20020014), (8,20030032), (C,AC010000) on consecutive cycles, starting in the second cycle after reset.
REQ-032 With out_ready=0 for 10 cycles -> out_valid=1, the head entry is held at (0,2001000A), imem_addr stops at 0x10 (FIFO_DEPTH=4), and perf_stall increments once per stalled cycle when FETCH_PERF_COUNTERS_EN is defined.
REQ-033 With a full buffer, a redirect of redirect_pc=0x14 in cycle N -> out_valid=0 in cycle N+1, and out is (0x14, mem[5]=10230002) in cycle N+2.
REQ-034 redirect_pc=0x0000000E -> fetch at 0x0000000C; and redirect_pc=0xFFFFFFFC -> out_pc sequence FFFFFFFC, 00000000.
REQ-035 Assert reset for one cycle mid-stream with 3 entries buffered -> next cycle out_valid=0, imem_addr=RESET_PC, and the first output is (RESET_PC, mem[0]).
REQ-036 Toggle out_ready randomly for 200 cycles without redirects -> out_pc increments by exactly 4 at every accepted transfer, with no drops or duplicates.
